// File: rtl/cubehash_core.sv
// cubehash_core
// CubeHash16/32-256 compression engine. It absorbs 256-bit message blocks
// into a 1024-bit state (32 x 32-bit words), runs one round per clock, and
// presents a 256-bit digest after finalization of the block flagged `last`.
//
// Ports:
//   clk        - core clock
//   rst_p      - asynchronous active-high reset; aborts any operation in flight
//   msg        - 256-bit message block, msg[255:248] is byte 0, valid with done
//   done       - one-cycle block-valid pulse
//   last       - sampled with done, marks the final block of a message
//   hash       - 256-bit digest, hash[255:248] is byte 0, held until next digest
//   hash_valid - one-cycle pulse in the cycle hash updates
//   busy       - high whenever a done pulse would be dropped (all but IDLE)
//   overrun    - sticky, set when done arrives while busy, cleared by reset
module cubehash_core #(
  parameter int ROUNDS      = 16,
  parameter int INIT_ROUNDS = 160,
  parameter int FIN_ROUNDS  = 160
) (
  input  logic         clk,
  input  logic         rst_p,
  input  logic [255:0] msg,
  input  logic         done,
  input  logic         last,
  output logic [255:0] hash,
  output logic         hash_valid,
  output logic         busy,
  output logic         overrun
);

  typedef enum logic [2:0] {
    S_LOADIV,
    S_INIT,
    S_IDLE,
    S_ABSORB,
    S_FINAL,
    S_OUT
  } state_t;

  // Words are little-endian groups of four message bytes, so both the input
  // and the output mapping are a per-word byte reversal.
  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  // One full CubeHash round. Word index n is the 5-bit ijklm value; the
  // upper half is reached by setting bit i, the swaps flip bits j, l, k and m.
  function automatic logic [31:0][31:0] cube_round(input logic [31:0][31:0] s);
    logic [31:0][31:0] y;
    logic [31:0][31:0] t;
    y = s;
    for (logic [4:0] n = 5'd0; n < 5'd16; n++) y[n | 5'd16] = y[n | 5'd16] + y[n];
    for (logic [4:0] n = 5'd0; n < 5'd16; n++) y[n] = {y[n][24:0], y[n][31:25]};
    t = y;
    for (logic [4:0] n = 5'd0; n < 5'd16; n++) y[n] = t[n ^ 5'd8];
    for (logic [4:0] n = 5'd0; n < 5'd16; n++) y[n] = y[n] ^ y[n | 5'd16];
    t = y;
    for (logic [4:0] n = 5'd0; n < 5'd16; n++) y[n | 5'd16] = t[(n ^ 5'd2) | 5'd16];
    for (logic [4:0] n = 5'd0; n < 5'd16; n++) y[n | 5'd16] = y[n | 5'd16] + y[n];
    for (logic [4:0] n = 5'd0; n < 5'd16; n++) y[n] = {y[n][20:0], y[n][31:21]};
    t = y;
    for (logic [4:0] n = 5'd0; n < 5'd16; n++) y[n] = t[n ^ 5'd4];
    for (logic [4:0] n = 5'd0; n < 5'd16; n++) y[n] = y[n] ^ y[n | 5'd16];
    t = y;
    for (logic [4:0] n = 5'd0; n < 5'd16; n++) y[n | 5'd16] = t[(n ^ 5'd1) | 5'd16];
    return y;
  endfunction

  // Digest byte b is byte (b mod 4) of word b/4; word 0 lands in hash[255:224].
  function automatic logic [255:0] pack_digest(input logic [31:0][31:0] s);
    logic [7:0][31:0] r;
    for (logic [3:0] w = 4'd0; w < 4'd8; w++) r[~w[2:0]] = bswap32(s[{2'b00, w[2:0]}]);
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [31:0][31:0] x_q, x_d;
  logic [31:0][31:0] x_round;
  logic [7:0]        cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [255:0]      hash_q, hash_d;
  logic              hash_valid_q, hash_valid_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic [7:0][31:0]  msg_words;

  assign msg_words = msg;
  assign x_round   = cube_round(x_q);

  // Next-state logic. The round counter is loaded on phase entry and the
  // phase ends in the cycle it reads 1, so each phase runs exactly its round
  // count. The digest and hash_valid are produced on the edge that enters
  // OUT, which makes the pulse coincide with the OUT cycle.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    hash_d       = hash_q;
    hash_valid_d = 1'b0;
    overrun_d    = overrun_q;

    if (done && (state_q != S_IDLE)) overrun_d = 1'b1;

    case (state_q)
      S_LOADIV: begin
        x_d     = '0;
        x_d[0]  = 32'd32;
        x_d[1]  = 32'd32;
        x_d[2]  = 32'(ROUNDS);
        cnt_d   = 8'(INIT_ROUNDS);
        state_d = S_INIT;
      end
      S_INIT: begin
        x_d   = x_round;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (done) begin
          last_d = last;
          for (logic [3:0] w = 4'd0; w < 4'd8; w++) begin
            x_d[{2'b00, w[2:0]}] = x_q[{2'b00, w[2:0]}] ^ bswap32(msg_words[~w[2:0]]);
          end
          cnt_d   = 8'(ROUNDS);
          state_d = S_ABSORB;
        end
      end
      S_ABSORB: begin
        x_d   = x_round;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          if (last_q) begin
            // Finalization marker goes onto the result of the last absorb round.
            x_d[31] = x_round[31] ^ 32'd1;
            cnt_d   = 8'(FIN_ROUNDS);
            state_d = S_FINAL;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_FINAL: begin
        x_d   = x_round;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          hash_d       = pack_digest(x_round);
          hash_valid_d = 1'b1;
          state_d      = S_OUT;
        end
      end
      S_OUT: begin
        state_d = S_LOADIV;
      end
      default: begin
        state_d = S_LOADIV;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset drops everything in flight and
  // restarts IV generation.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state_q      <= S_LOADIV;
      x_q          <= '0;
      cnt_q        <= '0;
      last_q       <= 1'b0;
      hash_q       <= '0;
      hash_valid_q <= 1'b0;
      busy_q       <= 1'b1;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      hash_q       <= hash_d;
      hash_valid_q <= hash_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign hash       = hash_q;
  assign hash_valid = hash_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_cubehash_core.sv
// tb_cubehash_core
// Self-checking bench for cubehash_core. A behavioural CubeHash model
// computes expected digests; expected results go into a scoreboard queue
// when the last block is driven and are compared when hash_valid pulses,
// together with the exact pulse cycle.
module tb_cubehash_core;

  localparam int ROUNDS      = 16;
  localparam int INIT_ROUNDS = 160;
  localparam int FIN_ROUNDS  = 160;
  localparam int LAT         = ROUNDS + FIN_ROUNDS + 1;

  logic         clk = 1'b0;
  logic         rst_p = 1'b1;
  logic [255:0] msg = '0;
  logic         done = 1'b0;
  logic         last = 1'b0;
  logic [255:0] hash;
  logic         hash_valid;
  logic         busy;
  logic         overrun;

  cubehash_core #(
    .ROUNDS     (ROUNDS),
    .INIT_ROUNDS(INIT_ROUNDS),
    .FIN_ROUNDS (FIN_ROUNDS)
  ) dut (
    .clk       (clk),
    .rst_p     (rst_p),
    .msg       (msg),
    .done      (done),
    .last      (last),
    .hash      (hash),
    .hash_valid(hash_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [255:0] digest;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   hvCount = 0;

  typedef struct packed {
    int               nblk;
    int               gap;
    logic [2:0][255:0] blk;
    logic             useModel;
    logic [255:0]     want;
  } vec_t;

  vec_t vecs[4];

  // ---------------- checking helpers ----------------
  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  task automatic checkInt(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // ---------------- reference model ----------------
  bit [31:0] mx [32];

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  task automatic modelRound();
    bit [31:0] t [32];
    for (int i = 0; i < 16; i++) mx[16 + i] += mx[i];
    for (int i = 0; i < 16; i++) mx[i] = (mx[i] << 7) | (mx[i] >> 25);
    t = mx;
    for (int i = 0; i < 16; i++) mx[i] = t[i ^ 8];
    for (int i = 0; i < 16; i++) mx[i] ^= mx[16 + i];
    t = mx;
    for (int i = 0; i < 16; i++) mx[16 + i] = t[16 + (i ^ 2)];
    for (int i = 0; i < 16; i++) mx[16 + i] += mx[i];
    for (int i = 0; i < 16; i++) mx[i] = (mx[i] << 11) | (mx[i] >> 21);
    t = mx;
    for (int i = 0; i < 16; i++) mx[i] = t[i ^ 4];
    for (int i = 0; i < 16; i++) mx[i] ^= mx[16 + i];
    t = mx;
    for (int i = 0; i < 16; i++) mx[16 + i] = t[16 + (i ^ 1)];
  endtask

  task automatic modelDigest(input int nblk, input logic [2:0][255:0] blk, output logic [255:0] dig);
    logic [255:0] cur;
    for (int i = 0; i < 32; i++) mx[i] = 32'd0;
    mx[0] = 32'd32;
    mx[1] = 32'd32;
    mx[2] = 32'(ROUNDS);
    repeat (INIT_ROUNDS) modelRound();
    for (int b = 0; b < nblk; b++) begin
      cur = blk[b];
      for (int w = 0; w < 8; w++) begin
        mx[w] ^= bswap(cur[255:224]);
        cur = cur << 32;
      end
      repeat (ROUNDS) modelRound();
    end
    mx[31] ^= 32'd1;
    repeat (FIN_ROUNDS) modelRound();
    dig = '0;
    for (int w = 0; w < 8; w++) dig = {dig[223:0], bswap(mx[w])};
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    exp_t e;
    logic prevHv;
    prevHv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_p) begin
        prevHv = 1'b0;
      end else begin
        if (prevHv) checkBit("hv_single_cycle", hash_valid, 1'b0);
        if (hash_valid) begin
          hvCount++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_hv: got pulse at cycle %0d expected none", cyc);
          end else begin
            e = sb.pop_front();
            checkOutput("digest", hash, e.digest);
            checkInt("digest_cycle", cyc, e.due);
          end
        end
        prevHv = hash_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end by %0t expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one done pulse; called at a negedge, returns one negedge later.
  task automatic applyStimulus(input logic [255:0] blk, input logic isLast);
    msg  = blk;
    done = 1'b1;
    last = isLast;
    @(negedge clk);
    done = 1'b0;
    last = 1'b0;
    msg  = '0;
  endtask

  task automatic sendLast(input logic [255:0] blk, input logic [255:0] want);
    exp_t e;
    e.digest = want;
    e.due    = cyc + LAT;
    sb.push_back(e);
    applyStimulus(blk, 1'b1);
  endtask

  task automatic waitIdle(input string name, input int bound);
    int k = 0;
    while (busy !== 1'b0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    checkBit(name, busy, 1'b0);
  endtask

  task automatic waitDigest(input string name, input int bound);
    int start = hvCount;
    int k = 0;
    while (hvCount == start && k < bound) begin
      @(negedge clk);
      k++;
    end
    checkInt(name, hvCount, start + 1);
  endtask

  task automatic runVector(input int i);
    for (int b = 0; b < vecs[i].nblk; b++) begin
      checkBit("busy_before_block", busy, 1'b0);
      if (b == vecs[i].nblk - 1) begin
        sendLast(vecs[i].blk[b], vecs[i].want);
      end else begin
        applyStimulus(vecs[i].blk[b], 1'b0);
        // last without done must be ignored
        last = 1'b1;
        waitCycles(vecs[i].gap - 1);
        last = 1'b0;
      end
    end
    waitDigest("vector_digest_arrives", 400);
    checkBit("vector_no_overrun", overrun, 1'b0);
    waitIdle("vector_back_to_idle", 400);
  endtask

  // ---------------- main test ----------------
  initial begin
    logic [255:0]      wantP;
    logic [255:0]      wantQ;
    logic [255:0]      blkQ;
    logic [2:0][255:0] tmpBlk;
    logic [255:0]      tmpDig;
    int                hvSnap;

    vecs[0].nblk     = 1;
    vecs[0].gap      = 0;
    vecs[0].blk      = '0;
    vecs[0].blk[0]   = {8'h80, 248'h0};
    vecs[0].useModel = 1'b0;
    vecs[0].want     = 256'h44c6de3ac6c73c391bf0906cb7482600ec06b216c7c54a2a8688a6a42676577d;

    vecs[1].nblk     = 1;
    vecs[1].gap      = 0;
    vecs[1].blk      = '0;
    vecs[1].blk[0]   = {24'h616263, 8'h80, 224'h0};
    vecs[1].useModel = 1'b1;
    vecs[1].want     = '0;

    vecs[2].nblk     = 3;
    vecs[2].gap      = 40;
    vecs[2].blk[0]   = 256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
    vecs[2].blk[1]   = 256'hdeadbeef_cafef00d_01234567_89abcdef_fedcba98_76543210_a5a5a5a5_5a5a5a5a;
    vecs[2].blk[2]   = {8'h80, 248'h0};
    vecs[2].useModel = 1'b1;
    vecs[2].want     = '0;

    vecs[3].nblk     = 2;
    vecs[3].gap      = ROUNDS + 1;
    vecs[3].blk      = '0;
    vecs[3].blk[0]   = {256{1'b1}};
    vecs[3].blk[1]   = 256'h11223344_55667788_99aabbcc_ddeeff00_0f1e2d3c_4b5a6978_87968574_80000000;
    vecs[3].useModel = 1'b1;
    vecs[3].want     = '0;

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].useModel) begin
        modelDigest(vecs[i].nblk, vecs[i].blk, tmpDig);
        vecs[i].want = tmpDig;
      end
    end
    wantP  = vecs[1].want;
    blkQ   = 256'hfedcba98_76543210_0f0f0f0f_f0f0f0f0_13579bdf_2468ace0_c3c3c3c3_80000000;
    tmpBlk = '0;
    tmpBlk[0] = blkQ;
    modelDigest(1, tmpBlk, wantQ);

    // Reset values and IV generation time
    rst_p = 1'b1;
    waitCycles(3);
    checkOutput("reset_hash", hash, 256'h0);
    checkBit("reset_hash_valid", hash_valid, 1'b0);
    checkBit("reset_overrun", overrun, 1'b0);
    checkBit("reset_busy", busy, 1'b1);
    rst_p = 1'b0;
    waitCycles(1 + INIT_ROUNDS - 1);
    checkBit("init_busy_last_cycle", busy, 1'b1);
    waitCycles(1);
    checkBit("init_idle_reached", busy, 1'b0);

    // Table of messages
    for (int i = 0; i < 4; i++) runVector(i);

    // Back-to-back messages with the digest held in between
    sendLast(vecs[1].blk[0], wantP);
    waitDigest("b2b_first_digest", 400);
    waitIdle("b2b_iv_regen", 400);
    checkOutput("b2b_hold_idle", hash, wantP);
    sendLast(blkQ, wantQ);
    waitCycles(LAT - 2);
    checkOutput("b2b_hold_before_second", hash, wantP);
    checkBit("b2b_no_early_hv", hash_valid, 1'b0);
    waitDigest("b2b_second_digest", 400);
    waitIdle("b2b_back_to_idle", 400);

    // done while busy: dropped, overrun set, digest unaffected
    checkBit("ovr_clear_before", overrun, 1'b0);
    sendLast(vecs[1].blk[0], wantP);
    checkBit("ovr_accept_from_idle", overrun, 1'b0);
    waitCycles(4);
    applyStimulus({256{1'b1}}, 1'b1);
    checkBit("ovr_set", overrun, 1'b1);
    waitDigest("ovr_digest", 400);
    checkBit("ovr_sticky", overrun, 1'b1);
    waitIdle("ovr_back_to_idle", 400);

    // Reset in the middle of finalization
    sendLast(blkQ, wantQ);
    waitCycles(60);
    #2;
    rst_p = 1'b1;
    #1;
    checkOutput("abort_hash_zero", hash, 256'h0);
    checkBit("abort_hv_zero", hash_valid, 1'b0);
    checkBit("abort_overrun_zero", overrun, 1'b0);
    checkBit("abort_busy", busy, 1'b1);
    sb.delete();
    hvSnap = hvCount;
    waitCycles(2);
    rst_p = 1'b0;
    waitIdle("abort_idle_again", 400);
    checkInt("abort_no_hash_valid", hvCount, hvSnap);

    // Empty message after the abort
    runVector(0);
    checkBit("final_overrun_clear", overrun, 1'b0);
    checkInt("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
